// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Main control FSM for a multicycle MIPS-style datapath. Sequences
//             fetch/decode/execute/memory/writeback per opcode, drives the
//             datapath mux selects and write enables, and watches memory
//             handshakes with a bounded wait counter that faults into a
//             sticky ERROR state.
//  Ports    : clk, rst_n (async, active-low)
//             opcode[5:0], zero, mem_ready          -- inputs
//             mem_req, mem_we, i_or_d               -- memory interface
//             ir_write, pc_write, reg_write         -- register write enables
//             pc_src[1:0], reg_dst, mem_to_reg,
//             alu_src_a, alu_src_b[1:0], alu_op[2:0] -- datapath controls
//             state[3:0] (debug), error (sticky fault)
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] pc_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [3:0] state,
  output logic       error
);

  localparam int             c_CW        = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [c_CW-1:0] c_WAIT_LAST = c_CW'(WAIT_LIMIT - 1);

  localparam logic [5:0] c_OP_R    = 6'h00;
  localparam logic [5:0] c_OP_LW   = 6'h23;
  localparam logic [5:0] c_OP_SW   = 6'h2B;
  localparam logic [5:0] c_OP_BEQ  = 6'h04;
  localparam logic [5:0] c_OP_J    = 6'h02;
  localparam logic [5:0] c_OP_ADDI = 6'h08;
  localparam logic [5:0] c_OP_ANDI = 6'h0C;
  localparam logic [5:0] c_OP_ORI  = 6'h0D;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_ERROR    = 4'd12
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [c_CW-1:0] r_wait_cnt;
  logic            w_mem_state;
  logic            w_waiting;
  logic            w_timeout;

  // Un-gated control values; write enables are masked by rst_n below.
  logic w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_reg_write;

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_waiting   = w_mem_state && !mem_ready;
  // The cycle that completes the WAIT_LIMIT-th consecutive wait faults on its edge.
  assign w_timeout   = w_waiting && (r_wait_cnt == c_WAIT_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          c_OP_LW, c_OP_SW:               w_next = S_MEM_ADDR;
          c_OP_R:                         w_next = S_R_EXEC;
          c_OP_BEQ:                       w_next = S_BRANCH;
          c_OP_J:                         w_next = S_JUMP;
          c_OP_ADDI, c_OP_ANDI, c_OP_ORI: w_next = S_I_EXEC;
          default:                        w_next = S_ERROR;
        endcase
      end
      S_MEM_ADDR: w_next = (opcode == c_OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) w_next = S_LW_WB;
      S_LW_WB:    w_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
      S_R_EXEC:   w_next = S_R_WB;
      S_R_WB:     w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_I_EXEC:   w_next = S_I_WB;
      S_I_WB:     w_next = S_FETCH;
      S_ERROR:    w_next = S_ERROR;
      default:    w_next = S_ERROR;
    endcase
    if (w_timeout) w_next = S_ERROR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      // Memory states only exit on mem_ready=1 (or fault), so clearing on any
      // non-waiting cycle guarantees a zero count on entry.
      if (w_waiting && !w_timeout) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                         r_wait_cnt <= '0;
    end
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    i_or_d      = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    pc_src      = 2'd0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_op      = 3'd1;
    error       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req  = 1'b1;
        alu_src_b  = 2'd1;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'd3;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_MEM_RD: begin
        w_mem_req = 1'b1;
        i_or_d    = 1'b1;
      end
      S_LW_WB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'd0;
      end
      S_R_WB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'd4;
        pc_src     = 2'd1;
        w_pc_write = zero;
      end
      S_JUMP: begin
        pc_src     = 2'd2;
        w_pc_write = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        if (opcode == c_OP_ANDI)     alu_op = 3'd2;
        else if (opcode == c_OP_ORI) alu_op = 3'd3;
        else                         alu_op = 3'd1;
      end
      S_I_WB:  w_reg_write = 1'b1;
      S_ERROR: error = 1'b1;
      default: error = 1'b1;
    endcase
  end

  // Reset must silence the memory port and all write enables immediately,
  // even though the state register already reads FETCH during reset.
  assign mem_req   = w_mem_req   & rst_n;
  assign mem_we    = w_mem_we    & rst_n;
  assign ir_write  = w_ir_write  & rst_n;
  assign pc_write  = w_pc_write  & rst_n;
  assign reg_write = w_reg_write & rst_n;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: max consecutive cycles a memory state waits for mem_ready before fault.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 opcode  in  6  instruction bits [31:26] from instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 mem_ready  in  1  memory completion strobe.
REQ-007 mem_req  out  1  memory access request.
REQ-008 mem_we  out  1  memory write enable (valid with mem_req).
REQ-009 i_or_d  out  1  address select: 0=PC, 1=ALU out.
REQ-010 ir_write, pc_write, reg_write  out  1 each  register write enables.
REQ-011 pc_src  out  2  0=ALU result, 1=ALU out (branch target), 2=jump target.
REQ-012 reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath mux selects.
REQ-013 alu_src_b  out  2  0=reg B, 1=constant 4, 2=sign-ext imm, 3=sign-ext imm<<2.
REQ-014 alu_op  out  3  to ALU_CTRL: 0=decode funct, 1=add, 2=and, 3=or, 4=sub.
REQ-015 state  out  4  current state code (debug).
REQ-016 error  out  1  sticky fault flag.

Function
REQ-017 States/codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, LW_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, ERROR 12; codes 13-15 unreachable, go to ERROR.
REQ-018 Opcodes: R 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08, andi 0x0C, ori 0x0D.
REQ-019 FETCH: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=1, pc_src=0; ir_write=pc_write=1 only in cycle mem_ready=1; advance to DECODE on that edge, else hold.
REQ-020 DECODE: alu_src_a=0, alu_src_b=3, alu_op=1; next by opcode: lw/sw->MEM_ADDR, R->R_EXEC, beq->BRANCH, j->JUMP, addi/andi/ori->I_EXEC, other->ERROR.
REQ-021 MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=1; lw->MEM_RD, sw->MEM_WR.
REQ-022 MEM_RD: mem_req=1, i_or_d=1, mem_we=0; to LW_WB when mem_ready=1. LW_WB: reg_write=1, reg_dst=0, mem_to_reg=1; ->FETCH.
REQ-023 MEM_WR: mem_req=1, mem_we=1, i_or_d=1; to FETCH when mem_ready=1.
REQ-024 R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=0; ->R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=4, pc_src=1, pc_write=zero; ->FETCH.
REQ-026 JUMP: pc_src=2, pc_write=1; ->FETCH.
REQ-027 I_EXEC: alu_src_a=1, alu_src_b=2, alu_op=1/2/3 for addi/andi/ori; ->I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; ->FETCH.
REQ-028 Unlisted outputs SHALL be 0 in each state; alu_op defaults to 1.
REQ-029 Latency (zero-wait memory), cycles FETCH-to-FETCH: R 4, lw 5, sw 4, beq 3, j 3, I-type 4.
REQ-030 Wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR and increment each cycle mem_ready=0 there; reaching WAIT_LIMIT SHALL enter ERROR next edge.
REQ-031 mem_ready outside memory states SHALL be ignored.
REQ-032 ERROR: all enables and mem_req 0, error=1; held until reset.

Reset
REQ-033 rst_n low SHALL immediately force state=FETCH, wait counter 0, error 0, and all write enables and mem_req 0 regardless of state, including mid-instruction or mid-wait.
REQ-034 First posedge after rst_n rises SHALL behave as FETCH cycle 1.

Verification
REQ-035 R-type (opcode 0x00), mem_ready always 1 -> states 0,1,6,7,0; alu_op 0 in R_EXEC; reg_write=1, reg_dst=1 in R_WB.
REQ-036 lw, mem_ready low 3 cycles in MEM_RD -> 3 extra MEM_RD cycles, then LW_WB with mem_to_reg=1; 8 cycles total.
REQ-037 beq zero=1 -> pc_write=1, pc_src=1 in BRANCH; zero=0 -> pc_write=0; both 3 cycles.
REQ-038 opcode 0x3F in DECODE -> ERROR, error=1, mem_req 0; stays until rst_n pulse.
REQ-039 mem_ready held 0 in FETCH, WAIT_LIMIT=15 -> ERROR after 15 wait cycles; 14 then ready -> no fault.
REQ-040 rst_n asserted in MEM_WR with mem_ready=0 -> mem_we/mem_req drop same cycle, state=0.
